// File: rtl/demux_1x64_pkg.sv
// Shared constants and group-decode helpers for the 1-to-64 demux.
// Imported by both the top level and the 16-bit group slice.
package demux_1x64_pkg;

    localparam int unsigned DEMUX_GRP_W   = 2;
    localparam int unsigned DEMUX_IDX_W   = 4;
    localparam int unsigned DEMUX_GRP_N   = 4;
    localparam int unsigned DEMUX_SLICE_W = 16;

    typedef logic [DEMUX_GRP_N-1:0] grp_oh_t;
    typedef logic [DEMUX_GRP_W-1:0] grp_t;
    typedef logic [DEMUX_IDX_W-1:0] idx_t;

    function automatic grp_oh_t grp_onehot(input grp_t grp);
        grp_oh_t oh;
        oh = '0;
        oh[grp] = 1'b1;
        return oh;
    endfunction

    // Inverse of grp_onehot; stage-1 keeps only the one-hot form.
    function automatic grp_t grp_index(input grp_oh_t oh);
        grp_t g;
        g = '0;
        for (int unsigned i = 0; i < DEMUX_GRP_N; i++) begin
            if (oh[i]) g = i[DEMUX_GRP_W-1:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/demux_1x16.sv
// One 16-bit group slice of the demux: owns its holding bits, its
// written mask and a registered all-written flag.
module demux_1x16
    import demux_1x64_pkg::*;
#(
    parameter int unsigned CLEAR_ON_WRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     clear,
    input  logic                     din,
    input  idx_t                     idx,
    output logic [DEMUX_SLICE_W-1:0] slice_out,
    output logic                     slice_full
);

    logic [DEMUX_SLICE_W-1:0] written;
    logic [DEMUX_SLICE_W-1:0] out_nxt;
    logic [DEMUX_SLICE_W-1:0] written_nxt;

    always_comb begin
        out_nxt     = slice_out;
        written_nxt = written;
        if (clear) begin
            out_nxt     = '0;
            written_nxt = '0;
        end else if (wr_en) begin
            if (CLEAR_ON_WRITE != 0) out_nxt = '0;
            out_nxt[idx]     = din;
            written_nxt[idx] = 1'b1;
        end
    end

    // Flag follows the post-update mask so it rises with the last landing write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_out  <= '0;
            written    <= '0;
            slice_full <= 1'b0;
        end else begin
            slice_out  <= out_nxt;
            written    <= written_nxt;
            slice_full <= &written_nxt;
        end
    end

endmodule

// File: rtl/demux_1x64.sv
// Registered 1-to-64 bit demultiplexer: stage 1 decodes the group,
// stage 2 writes one bit into one of four 16-bit slices.
module demux_1x64
    import demux_1x64_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned SEL_WIDTH      = 6,
    parameter int unsigned CLEAR_ON_WRITE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic [SEL_WIDTH-1:0]  out_sel,
    output logic                  full
);

    logic    s1_valid;
    logic    s1_bit;
    idx_t    s1_idx;
    grp_oh_t s1_grp_oh;

    logic [DEMUX_GRP_N-1:0] slice_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bit    <= 1'b0;
            s1_idx    <= '0;
            s1_grp_oh <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_bit    <= in;
                s1_idx    <= sel[DEMUX_IDX_W-1:0];
                s1_grp_oh <= grp_onehot(sel[SEL_WIDTH-1:DEMUX_IDX_W]);
            end
        end
    end

    // A landing write coinciding with clear is dropped, so no pulse either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
        end else begin
            out_valid <= s1_valid & ~clear;
            if (s1_valid) out_sel <= {grp_index(s1_grp_oh), s1_idx};
        end
    end

    for (genvar g = 0; g < DEMUX_GRP_N; g++) begin : g_slice
        demux_1x16 #(
            .CLEAR_ON_WRITE(CLEAR_ON_WRITE)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (s1_valid & s1_grp_oh[g] & ~clear),
            .clear      (clear),
            .din        (s1_bit),
            .idx        (s1_idx),
            .slice_out  (out[g*DEMUX_SLICE_W +: DEMUX_SLICE_W]),
            .slice_full (slice_full[g])
        );
    end

    assign full = &slice_full;

endmodule

// File: tb/tb_demux_1x64.sv
// Scoreboard bench for demux_1x64; one instance per CLEAR_ON_WRITE setting,
// both driven by the same directed write sequence.
module tb_demux_1x64;

    typedef struct {
        logic [5:0]  sel;
        logic [63:0] out;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in = 1'b0;
    logic [5:0]  sel = '0;
    logic        clear = 1'b0;

    logic [63:0] out0, out1;
    logic        out_valid0, out_valid1;
    logic [5:0]  out_sel0, out_sel1;
    logic        full0, full1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] m0 = '0, w0 = '0, m1 = '0, w1 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_1x64 #(.DATA_WIDTH(64), .SEL_WIDTH(6), .CLEAR_ON_WRITE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .sel(sel), .clear(clear),
        .out(out0), .out_valid(out_valid0), .out_sel(out_sel0), .full(full0)
    );

    demux_1x64 #(.DATA_WIDTH(64), .SEL_WIDTH(6), .CLEAR_ON_WRITE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .sel(sel), .clear(clear),
        .out(out1), .out_valid(out_valid1), .out_sel(out_sel1), .full(full1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every landing pulse must match the oldest outstanding write.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    check("dut0 spurious out_valid", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    check("dut0 out_sel", {58'd0, out_sel0}, {58'd0, e.sel});
                    check("dut0 out", out0, e.out);
                    check("dut0 full", {63'd0, full0}, {63'd0, e.full});
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    check("dut1 spurious out_valid", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    check("dut1 out_sel", {58'd0, out_sel1}, {58'd0, e.sel});
                    check("dut1 out", out1, e.out);
                    check("dut1 full", {63'd0, full1}, {63'd0, e.full});
                end
            end
        end
    end

    task automatic model_write(input logic [5:0] s, input logic b, input bit push);
        int unsigned base;
        m0[s] = b;
        w0[s] = 1'b1;
        base = {26'd0, s[5:4], 4'd0};
        for (int unsigned i = 0; i < 16; i++) m1[base + i] = 1'b0;
        m1[s] = b;
        w1[s] = 1'b1;
        if (push) begin
            q0.push_back('{sel: s, out: m0, full: &w0});
            q1.push_back('{sel: s, out: m1, full: &w1});
        end
    endtask

    task automatic model_clear();
        m0 = '0; w0 = '0; m1 = '0; w1 = '0;
    endtask

    task automatic wr(input logic [5:0] s, input logic b);
        in_valid = 1'b1;
        sel      = s;
        in       = b;
        model_write(s, b, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in       = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        in_valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("reset out", out0, 64'd0);
        check("reset out_valid", {63'd0, out_valid0}, 64'd0);
        check("reset full", {63'd0, full0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single write, two-edge latency
        wr(6'd37, 1'b1);
        in_valid = 1'b0;
        check("single not yet landed", out0, 64'd0);
        @(posedge clk); #1;
        check("single out", out0, 64'h0000_0020_0000_0000);
        check("single out_valid", {63'd0, out_valid0}, 64'd1);
        @(posedge clk); #1;
        check("single out_valid drop", {63'd0, out_valid0}, 64'd0);
        idle(2);

        // Reset with a write sitting in stage 1
        wr(6'd3, 1'b1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        model_clear();
        #1;
        check("async reset out", out0, 64'd0);
        check("async reset out_valid", {63'd0, out_valid0}, 64'd0);
        check("async reset full", {63'd0, full0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        check("lost write stays lost", out0, 64'd0);

        // Back-to-back sweep of all 64 bits
        for (int i = 0; i < 64; i++) wr(i[5:0], 1'b1);
        idle(3);
        check("sweep out", out0, '1);
        check("sweep full", {63'd0, full0}, 64'd1);
        check("sweep cow out", out1, 64'h8000_8000_8000_8000);

        // Overwrite the same index on consecutive cycles
        wr(6'd5, 1'b1);
        wr(6'd5, 1'b0);
        idle(3);
        check("overwrite out", out0, 64'hFFFF_FFFF_FFFF_FFDF);

        // Clear collides with a landing write; next capture survives
        wr(6'd10, 1'b1);
        q0.pop_back();
        q1.pop_back();
        model_clear();
        clear = 1'b1;
        sel   = 6'd11;
        in    = 1'b1;
        model_write(6'd11, 1'b1, 1'b1);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear out", out0, 64'd0);
        check("clear out_valid", {63'd0, out_valid0}, 64'd0);
        check("clear full", {63'd0, full0}, 64'd0);
        @(posedge clk); #1;
        check("after clear out", out0, 64'h800);
        check("after clear out_valid", {63'd0, out_valid0}, 64'd1);
        check("after clear out_sel", {58'd0, out_sel0}, 64'd11);
        idle(2);

        // Clear-on-write: only the addressed slice collapses
        do_clear();
        for (int i = 0; i < 64; i++) wr(i[5:0], 1'b1);
        wr(6'd20, 1'b1);
        idle(3);
        check("cow slice1", {48'd0, out1[31:16]}, 64'h0010);
        check("cow others", out1, 64'h8000_8000_0010_8000);
        check("no-cow holds", out0, '1);

        idle(2);
        check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
